// File: rtl/tank_plant_pkg.sv
// Shared constants and types for the tank plant model.
// These cover the default geometry, the sensor indices and the sensor FSM encoding.
package tank_plant_pkg;

  localparam int LEVEL_W_DEF    = 8;
  localparam int LEVEL_MAX_DEF  = 200;
  localparam int TH0_DEF        = 20;
  localparam int TH1_DEF        = 100;
  localparam int TH2_DEF        = 180;
  localparam int HYST_DEF       = 2;
  localparam int FILL_STEP_DEF  = 2;
  localparam int DRAIN_STEP_DEF = 1;
  localparam int TICK_DIV_DEF   = 4;

  localparam int SENS_LOW  = 0;
  localparam int SENS_HALF = 1;
  localparam int SENS_FULL = 2;
  localparam int NUM_SENS  = 3;

  typedef enum logic {
    OFF = 1'b0,
    ON  = 1'b1
  } sens_state_e;

  // A divider of 1 still needs a one-bit counter so the ports stay legal.
  function automatic int cnt_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/level_sensor_hyst.sv
// Single level sensor with release hysteresis, evaluated on the registered level.
// force_i loads the raw threshold comparison directly and bypasses the hysteresis band.
module level_sensor_hyst
  import tank_plant_pkg::*;
#(
  parameter int LEVEL_W = LEVEL_W_DEF,
  parameter int TH      = TH1_DEF,
  parameter int HYST    = HYST_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [LEVEL_W-1:0] level_i,
  input  logic               force_i,
  output logic               s_o
);

  localparam logic [LEVEL_W-1:0] TH_ON  = LEVEL_W'(TH);
  localparam logic [LEVEL_W-1:0] TH_OFF = LEVEL_W'(TH - HYST);

  sens_state_e state_q;

  // NOTE: state registers use non-blocking assignments only, so every
  // flop samples the pre-edge values and simulation matches hardware.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= OFF;
    end else if (force_i) begin
      state_q <= (level_i >= TH_ON) ? ON : OFF;
    end else if (state_q == OFF) begin
      if (level_i >= TH_ON) state_q <= ON;
    end else begin
      if (level_i < TH_OFF) state_q <= OFF;
    end
  end

  assign s_o = (state_q == ON);

endmodule

// File: rtl/tank_level_plant.sv
// Tank plant: tick divider, saturating level integrator, sticky over/underflow flags
// and three hysteretic level sensors feeding back to the pump controller.
module tank_level_plant
  import tank_plant_pkg::*;
#(
  parameter int LEVEL_W    = LEVEL_W_DEF,
  parameter int LEVEL_MAX  = LEVEL_MAX_DEF,
  parameter int TH0        = TH0_DEF,
  parameter int TH1        = TH1_DEF,
  parameter int TH2        = TH2_DEF,
  parameter int HYST       = HYST_DEF,
  parameter int FILL_STEP  = FILL_STEP_DEF,
  parameter int DRAIN_STEP = DRAIN_STEP_DEF,
  parameter int TICK_DIV   = TICK_DIV_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pump,
  input  logic               drain_en,
  input  logic               level_load,
  input  logic [LEVEL_W-1:0] level_init,
  input  logic               clr_flags,
  output logic               S0,
  output logic               S1,
  output logic               S2,
  output logic [LEVEL_W-1:0] level,
  output logic               tick,
  output logic               overflow,
  output logic               underflow
);

  localparam int CNT_W = cnt_width(TICK_DIV);
  localparam int SUM_W = LEVEL_W + 2;

  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]        CNT_ONE  = CNT_W'(1);
  localparam logic [LEVEL_W-1:0]      MAX_L    = LEVEL_W'(LEVEL_MAX);
  localparam logic signed [SUM_W-1:0] MAX_S    = SUM_W'(LEVEL_MAX);
  localparam logic signed [SUM_W-1:0] FILL_S   = SUM_W'(FILL_STEP);
  localparam logic signed [SUM_W-1:0] DRAIN_S  = SUM_W'(DRAIN_STEP);

  logic [CNT_W-1:0]        tick_cnt_q, tick_cnt_d;
  logic [LEVEL_W-1:0]      level_q, level_d;
  logic                    overflow_q, overflow_d;
  logic                    underflow_q, underflow_d;
  logic                    load_q;
  logic signed [SUM_W-1:0] sum;
  logic                    ovf_set, unf_set;
  logic [NUM_SENS-1:0]     sens;

  assign tick = (tick_cnt_q == CNT_LAST);

  // NOTE: every always_comb output gets a default at the top, so no path
  // through the block can leave a variable unassigned and infer a latch.
  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + CNT_ONE;
    level_d    = level_q;
    ovf_set    = 1'b0;
    unf_set    = 1'b0;

    sum = $signed({2'b00, level_q});
    if (pump)     sum = sum + FILL_S;
    if (drain_en) sum = sum - DRAIN_S;

    if (level_load) begin
      // A load wins over a coincident tick and restarts the divider.
      tick_cnt_d = '0;
      level_d    = (level_init > MAX_L) ? MAX_L : level_init;
    end else if (tick) begin
      if (sum > MAX_S) begin
        level_d = MAX_L;
        ovf_set = 1'b1;
      end else if (sum[SUM_W-1]) begin
        level_d = '0;
        unf_set = 1'b1;
      end else begin
        level_d = sum[LEVEL_W-1:0];
      end
    end

    overflow_d  = ovf_set | (overflow_q & ~clr_flags);
    underflow_d = unf_set | (underflow_q & ~clr_flags);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q  <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      load_q      <= 1'b0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      load_q      <= level_load;
    end
  end

  level_sensor_hyst #(.LEVEL_W(LEVEL_W), .TH(TH0), .HYST(HYST)) u_sens_low (
    .clk     (clk),
    .reset   (reset),
    .level_i (level_q),
    .force_i (load_q),
    .s_o     (sens[SENS_LOW])
  );

  level_sensor_hyst #(.LEVEL_W(LEVEL_W), .TH(TH1), .HYST(HYST)) u_sens_half (
    .clk     (clk),
    .reset   (reset),
    .level_i (level_q),
    .force_i (load_q),
    .s_o     (sens[SENS_HALF])
  );

  level_sensor_hyst #(.LEVEL_W(LEVEL_W), .TH(TH2), .HYST(HYST)) u_sens_full (
    .clk     (clk),
    .reset   (reset),
    .level_i (level_q),
    .force_i (load_q),
    .s_o     (sens[SENS_FULL])
  );

  assign S0        = sens[SENS_LOW];
  assign S1        = sens[SENS_HALF];
  assign S2        = sens[SENS_FULL];
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_tank_level_plant.sv
// Bench for tank_level_plant: an integer model of the tank is compared on every
// negative clock edge, and directed scenarios add literal expectations.
module tb_tank_level_plant;

  localparam int LMAX  = 200;
  localparam int HY    = 2;
  localparam int FILL  = 2;
  localparam int DRAIN = 1;
  localparam int DIV   = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pump = 1'b0;
  logic       drain_en = 1'b0;
  logic       level_load = 1'b0;
  logic [7:0] level_init = 8'd0;
  logic       clr_flags = 1'b0;
  logic       S0, S1, S2, tick, overflow, underflow;
  logic [7:0] level;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  tank_level_plant dut (
    .clk        (clk),
    .reset      (reset),
    .pump       (pump),
    .drain_en   (drain_en),
    .level_load (level_load),
    .level_init (level_init),
    .clr_flags  (clr_flags),
    .S0         (S0),
    .S1         (S1),
    .S2         (S2),
    .level      (level),
    .tick       (tick),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int thr(input int k);
    case (k)
      0:       return 20;
      1:       return 100;
      default: return 180;
    endcase
  endfunction

  // Tank model: level in plain integers, cycles counted since the last update.
  int m_level  = 0;
  int m_cnt    = 0;
  bit m_s [3]  = '{0, 0, 0};
  bit m_ovf    = 1'b0;
  bit m_unf    = 1'b0;
  bit m_forced = 1'b0;

  always @(posedge clk) begin : model
    int nxt;
    bit bo, bu;
    if (reset) begin
      m_level = 0; m_cnt = 0; m_ovf = 0; m_unf = 0; m_forced = 0;
      for (int k = 0; k < 3; k++) m_s[k] = 0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (m_forced)                 m_s[k] = (m_level >= thr(k));
        else if (m_level >= thr(k))   m_s[k] = 1;
        else if (m_level < thr(k)-HY) m_s[k] = 0;
      end
      m_forced = level_load;
      bo = 0;
      bu = 0;
      if (level_load) begin
        m_level = (int'(level_init) > LMAX) ? LMAX : int'(level_init);
        m_cnt   = 0;
      end else if (m_cnt == DIV - 1) begin
        nxt = m_level + (pump ? FILL : 0) - (drain_en ? DRAIN : 0);
        if (nxt > LMAX)   begin m_level = LMAX; bo = 1; end
        else if (nxt < 0) begin m_level = 0;    bu = 1; end
        else              m_level = nxt;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
      m_ovf = bo || (m_ovf && !clr_flags);
      m_unf = bu || (m_unf && !clr_flags);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("level",     32'(level),     32'(m_level));
      check("tick",      32'(tick),      32'(m_cnt == DIV - 1));
      check("S0",        32'(S0),        32'(m_s[0]));
      check("S1",        32'(S1),        32'(m_s[1]));
      check("S2",        32'(S2),        32'(m_s[2]));
      check("overflow",  32'(overflow),  32'(m_ovf));
      check("underflow", 32'(underflow), 32'(m_unf));
      check("sens_order", 32'((!S2 || S1) && (!S1 || S0)), 32'd1);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [7:0] v);
    level_load = 1'b1;
    level_init = v;
    step(1);
    level_load = 1'b0;
  endtask

  initial begin
    // Reset state
    step(1);
    chk_en = 1'b1;
    check("rst_level", 32'(level), 32'd0);
    check("rst_sens",  32'({S2, S1, S0}), 32'd0);
    check("rst_tick",  32'(tick), 32'd0);
    check("rst_flags", 32'({overflow, underflow}), 32'd0);

    // Fill from empty
    reset = 1'b0;
    pump  = 1'b1;
    step(3);
    check("fill_e3", 32'(level), 32'd0);
    check("fill_tick_e3", 32'(tick), 32'd1);
    step(1);
    check("fill_e4", 32'(level), 32'd2);
    step(36);
    check("fill_e40", 32'(level), 32'd20);
    check("fill_S0_e40", 32'(S0), 32'd0);
    step(1);
    check("fill_S0_e41", 32'(S0), 32'd1);
    check("fill_S12_e41", 32'({S2, S1}), 32'd0);

    // Hysteresis on S1 while draining from 101
    pump = 1'b0;
    drain_en = 1'b1;
    load(8'd101);
    check("hyst_load", 32'(level), 32'd101);
    check("hyst_S1_lag", 32'(S1), 32'd0);
    step(1);
    check("hyst_S1_on", 32'(S1), 32'd1);
    step(11);
    check("hyst_lvl98", 32'(level), 32'd98);
    check("hyst_S1_98", 32'(S1), 32'd1);
    step(4);
    check("hyst_lvl97", 32'(level), 32'd97);
    check("hyst_S1_97lag", 32'(S1), 32'd1);
    step(1);
    check("hyst_S1_off", 32'(S1), 32'd0);

    // Overfill: 198 -> 200 exact, then clipped
    pump = 1'b1;
    drain_en = 1'b0;
    load(8'd198);
    step(1);
    check("ovf_S2", 32'(S2), 32'd1);
    step(3);
    check("ovf_t1_lvl", 32'(level), 32'd200);
    check("ovf_t1_flag", 32'(overflow), 32'd0);
    step(4);
    check("ovf_t2_lvl", 32'(level), 32'd200);
    check("ovf_t2_flag", 32'(overflow), 32'd1);
    clr_flags = 1'b1;
    step(1);
    clr_flags = 1'b0;
    check("ovf_clr", 32'(overflow), 32'd0);
    step(3);
    check("ovf_reset", 32'(overflow), 32'd1);
    step(3);
    clr_flags = 1'b1;
    step(1);
    check("ovf_set_wins", 32'(overflow), 32'd1);
    step(1);
    clr_flags = 1'b0;
    check("ovf_clr2", 32'(overflow), 32'd0);

    // Dry tank, then pump and drain together
    pump = 1'b0;
    drain_en = 1'b1;
    load(8'd0);
    step(4);
    check("dry_lvl", 32'(level), 32'd0);
    check("dry_unf", 32'(underflow), 32'd1);
    pump = 1'b1;
    step(4);
    check("net_lvl1", 32'(level), 32'd1);
    step(4);
    check("net_lvl2", 32'(level), 32'd2);

    // Load colliding with a tick: clamp, no flag, divider restarts
    step(3);
    check("coll_tick", 32'(tick), 32'd1);
    drain_en = 1'b0;
    load(8'd250);
    check("coll_lvl", 32'(level), 32'd200);
    check("coll_tick0", 32'(tick), 32'd0);
    check("coll_ovf", 32'(overflow), 32'd0);
    step(3);
    check("coll_tick_late", 32'(tick), 32'd1);
    check("coll_ovf_late", 32'(overflow), 32'd0);
    step(1);
    check("coll_ovf_set", 32'(overflow), 32'd1);

    // Reset mid-run overrides a coincident load
    load(8'd150);
    step(1);
    check("mid_S1", 32'({S2, S1, S0}), 32'b011);
    reset = 1'b1;
    level_load = 1'b1;
    level_init = 8'd100;
    step(1);
    check("mid_rst_lvl", 32'(level), 32'd0);
    check("mid_rst_sens", 32'({S2, S1, S0}), 32'd0);
    check("mid_rst_flags", 32'({overflow, underflow}), 32'd0);
    check("mid_rst_tick", 32'(tick), 32'd0);
    reset = 1'b0;
    level_load = 1'b0;
    pump = 1'b0;
    step(1);
    check("mid_post_lvl", 32'(level), 32'd0);

    // Inputs toggling between ticks: only values present at tick edges count
    load(8'd99);
    for (int i = 0; i < 64; i++) begin
      pump     = (i % 3 == 0);
      drain_en = (i % 5 < 2);
      step(1);
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
